// File: rtl/period_timer_bank.sv
// period_timer_bank: NCH independent programmable period timers with start/stop,
// one-shot mode, shadowed period and done/err/busy status.
module period_timer_bank #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       stop,
    input  logic [NCH-1:0]       mode,
    input  logic [NCH*WIDTH-1:0] period_sel,
    output logic [NCH-1:0]       en,
    output logic [NCH-1:0]       done,
    output logic [NCH-1:0]       err,
    output logic [NCH-1:0]       busy
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state     [NCH];
    state_t           w_state_nxt [NCH];
    logic [WIDTH-1:0] r_count     [NCH];
    logic [WIDTH-1:0] w_count_nxt [NCH];
    logic [WIDTH-1:0] r_period    [NCH];
    logic [WIDTH-1:0] w_period_nxt[NCH];
    logic [WIDTH-1:0] w_sel       [NCH];
    logic [NCH-1:0]   r_mode, w_mode_nxt, w_en_nxt, w_done_nxt, w_err_nxt;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_sel[i]        = period_sel[i*WIDTH +: WIDTH];
            w_state_nxt[i]  = r_state[i];
            w_count_nxt[i]  = r_count[i];
            w_period_nxt[i] = r_period[i];
            w_mode_nxt[i]   = r_mode[i];
            w_en_nxt[i]     = 1'b0;
            w_done_nxt[i]   = 1'b0;
            w_err_nxt[i]    = 1'b0;
            busy[i]         = (r_state[i] == RUN);
            if (stop[i]) begin
                w_state_nxt[i] = IDLE;
                w_count_nxt[i] = '0;
            end else if (start[i]) begin
                if (w_sel[i] != '0) begin
                    w_state_nxt[i]  = RUN;
                    w_count_nxt[i]  = '0;
                    w_period_nxt[i] = w_sel[i];
                    w_mode_nxt[i]   = mode[i];
                end else begin
                    w_err_nxt[i] = 1'b1;
                end
            end else if (r_state[i] == RUN) begin
                // terminal count wraps by compare, so the counter never reaches period_q
                if (r_count[i] == r_period[i] - WIDTH'(1)) begin
                    w_count_nxt[i] = '0;
                    w_en_nxt[i]    = 1'b1;
                    if (r_mode[i]) begin
                        w_done_nxt[i]  = 1'b1;
                        w_state_nxt[i] = IDLE;
                    end else if (w_sel[i] != '0) begin
                        w_period_nxt[i] = w_sel[i];
                    end
                end else begin
                    w_count_nxt[i] = r_count[i] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i]  <= IDLE;
                r_count[i]  <= '0;
                r_period[i] <= '0;
            end
            r_mode <= '0;
            en     <= '0;
            done   <= '0;
            err    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i]  <= w_state_nxt[i];
                r_count[i]  <= w_count_nxt[i];
                r_period[i] <= w_period_nxt[i];
            end
            r_mode <= w_mode_nxt;
            en     <= w_en_nxt;
            done   <= w_done_nxt;
            err    <= w_err_nxt;
        end
    end
endmodule
